// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store initiator: data width, access sizes,
// FSM states and the alignment rule.
package mem_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_t;

    // An access must be naturally aligned to its own size.
    function automatic logic is_misaligned(input logic [2:0] off, input size_t size);
        logic r;
        unique case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus doubleword memory port of mem_access_ctrl.
// The master side is the datapath together with Data_Memory.
interface mem_access_ctrl_if #(
    parameter int unsigned XLEN = mem_pkg::XLEN
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misaligned;
    logic            MemRead;
    logic            MemWrite;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
               MemRead, MemWrite, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane alignment: load extraction with sign/zero extension
// and store merge of right-justified data into a captured doubleword.
module lane_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = mem_pkg::XLEN
) (
    input  logic [2:0]      i_off,
    input  size_t           i_size,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load,
    output logic [XLEN-1:0] o_store
);
    logic [5:0]      w_sh;
    logic [XLEN-1:0] w_rshift;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_lane_mask;
    logic            w_sign;

    assign w_sh        = {i_off, 3'b000};
    assign w_rshift    = i_rdata >> w_sh;
    assign w_lane_mask = w_mask << w_sh;

    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        unique case (i_size)
            SZ_B: begin
                w_mask = {{(XLEN-8){1'b0}}, 8'hFF};
                w_sign = w_rshift[7];
            end
            SZ_H: begin
                w_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
                w_sign = w_rshift[15];
            end
            SZ_W: begin
                w_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
                w_sign = w_rshift[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
    end

    // Sign fill lands only in bits above the access width; doubles have none.
    assign o_load  = (w_rshift & w_mask) | ((!i_unsigned && w_sign) ? ~w_mask : '0);
    assign o_store = (i_rdata & ~w_lane_mask) | ((i_wdata << w_sh) & w_lane_mask);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: one request at a time, read-modify-write for
// sub-doubleword stores, one response pulse per accepted request.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = mem_pkg::XLEN
) (
    input logic               clk,
    input logic               reset,
    mem_access_ctrl_if.slave  bus
);
    state_t          r_state;
    state_t          w_next;
    logic            r_write;
    size_t           r_size;
    logic            r_unsigned;
    logic [2:0]      r_off;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_misal;

    logic            w_accept;
    logic            w_misal;
    logic            w_dstore;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_store;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);
    assign w_misal  = is_misaligned(bus.req_addr[2:0], size_t'(bus.req_size));
    assign w_dstore = bus.req_write && (size_t'(bus.req_size) == SZ_D);

    lane_align #(.XLEN(XLEN)) u_lane_align (
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_rdata    (bus.mem_rdata),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_store    (w_store)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misal)       w_next = ST_RESP;
                    else if (w_dstore) w_next = ST_WR;
                    else               w_next = ST_RD;
                end
            end
            ST_RD:   w_next = ST_CAP;
            ST_CAP:  w_next = r_write ? ST_WR : ST_RESP;
            ST_WR:   w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_write     <= 1'b0;
            r_size      <= SZ_B;
            r_unsigned  <= 1'b0;
            r_off       <= '0;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_misal     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write    <= bus.req_write;
                        r_size     <= size_t'(bus.req_size);
                        r_unsigned <= bus.req_unsigned;
                        r_off      <= bus.req_addr[2:0];
                        r_wdata    <= bus.req_wdata;
                        r_misal    <= w_misal;
                        r_rdata    <= '0;
                        r_mem_addr <= w_misal ? '0 : {bus.req_addr[XLEN-1:3], 3'b000};
                        if (!w_misal && w_dstore) r_mem_wdata <= bus.req_wdata;
                    end
                end
                ST_CAP: begin
                    if (r_write) r_mem_wdata <= w_store;
                    else         r_rdata     <= w_load;
                end
                ST_RESP: begin
                    r_mem_addr <= '0;
                    r_misal    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready       = (r_state == ST_IDLE);
    assign bus.resp_valid      = (r_state == ST_RESP);
    assign bus.MemRead         = (r_state == ST_RD);
    assign bus.MemWrite        = (r_state == ST_WR);
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.resp_rdata      = r_rdata;
    assign bus.resp_misaligned = r_misal;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator that sits between the datapath's memory stage and `Data_Memory`. It accepts one load or store request at a time over a valid/ready handshake. It drives the doubleword-wide memory port (`MemRead`, `MemWrite`, address, write data) and performs byte/half/word/double access. Sub-doubleword stores are done by read-modify-write; loads are sign- or zero-extended. It returns exactly one response pulse per accepted request.

## Interface
Parameters:
- `XLEN`, 64, data and address width.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned`  in  1  zero-extend load result; ignored for stores and for double loads.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores.
- `resp_misaligned`  out  1  request faulted; no memory access was made.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `mem_addr`  out  XLEN  doubleword address, equal to `req_addr & ~7`.
- `mem_wdata`  out  XLEN  doubleword written to memory.
- `mem_rdata`  in  XLEN  memory read data, valid the cycle after `MemRead`.

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP.
- `req_ready` = 1 only in IDLE. A request is accepted on an edge where `req_valid && req_ready`. Request fields are latched at acceptance; inputs are don't-care afterwards.
- Misalignment check: `req_addr` mod (1<<`req_size`) != 0. On a misaligned request the FSM goes IDLE→RESP with `resp_misaligned`=1 and `resp_rdata`=0. No strobe is issued.
- Load: IDLE→RD→CAP→RESP.
  - In CAP, `mem_rdata` is shifted right by 8*addr[2:0].
  - The result is truncated to the access size, then extended: zero-extend if `req_unsigned`, else sign-extend.
  - The extended value is registered into `resp_rdata`.
- Double store: IDLE→WR→RESP, with `mem_wdata` = `req_wdata`.
- Sub-double store: IDLE→RD→CAP→WR→RESP.
  - In CAP, the selected bytes of the captured doubleword are replaced by the low bytes of `req_wdata`, little-endian, starting at lane addr[2:0].
  - All other bytes keep their captured value.
- `MemRead` = (state==RD). `MemWrite` = (state==WR). `mem_addr` is held stable from RD/WR entry through RESP and is 0 in IDLE.
- RESP lasts exactly one cycle, then the FSM returns to IDLE. A new request can be accepted on the edge that ends the first IDLE cycle after RESP.
- Reset (`reset`==0 at an edge):
  - FSM → IDLE.
  - `req_ready`=1; `resp_valid`, `resp_rdata`, `resp_misaligned`, `MemRead`, `MemWrite`, `mem_addr`, `mem_wdata` = 0.
  - Any in-flight request is dropped with no response.
  - A WR cycle coinciding with the reset edge may still commit in memory, because the strobe was already high during that cycle.
- `req_valid` asserted while the FSM is not in IDLE is ignored; the request is not queued.

## Timing
Cycle 0 is the acceptance edge.
- Load: `MemRead` high in cycle 1, data captured at the end of cycle 2, `resp_valid` in cycle 3. Latency 3.
- Double store: `MemWrite` in cycle 1, `resp_valid` in cycle 2.
- Sub-double store: `MemRead` in cycle 1, merge in cycle 2, `MemWrite` in cycle 3, `resp_valid` in cycle 4.
- Misaligned request: `resp_valid` in cycle 1.
- All outputs are registered or decoded from registered state. There is no combinational path from `req_*` or `mem_rdata` to any output.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - FSM state encoding;
  - `XLEN`.
- Sub-module `lane_align`: purely combinational. It implements both load extraction/extension and store byte merge from (addr[2:0], size, unsigned, rdata, wdata). It is reused later by the instruction-fetch path.

## Test plan
- Memory doubleword at 0x10 preloaded with 0x8877665544332211.
  - Byte load, addr 0x17, signed → `resp_rdata`=0xFFFF_FFFF_FFFF_FF88, `resp_valid` 3 cycles after acceptance.
  - Same access with `req_unsigned`=1 → 0x88.
- Word store 0xDEADBEEF at 0x14 into the same doubleword → `MemRead` in cycle 1, `MemWrite` in cycle 3 with `mem_wdata`=0xDEADBEEF44332211, `resp_valid` in cycle 4.
- Half load at 0x13 → `resp_misaligned`=1 in cycle 1; `MemRead` and `MemWrite` never asserted.
- Double store 0x0123456789ABCDEF at 0x20, then double load from 0x20 → load returns 0x0123456789ABCDEF; `req_ready` is low from the cycle after acceptance until the cycle after RESP.
- `reset` driven to 0 during CAP of a word load → next cycle all outputs are 0 and `req_ready`=1; no `resp_valid` ever appears; a subsequent load completes normally.
- `req_valid` held high continuously for back-to-back loads → exactly one `resp_valid` per accepted request, and no acceptance occurs while the FSM is outside IDLE.
